rf_writeback_queue: RTL and testbench

- Write-side producer for the 64-bit, 32-entry register file. Drives its RegWrite/WriteReg/WriteData port.
- Buffers completed results from execute/load units in a small in-order FIFO and issues at most one register-file write per clock.
- Provides a combinational forwarding lookup, so readers can obtain values that are still pending in the queue.
- Sits between the result bus and the register file write port.

---
 rtl/rf_writeback_queue.sv | 103 ++++++++++
 tb/tb_rf_writeback_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the 64-bit register-file write port.
// Accepts at most one result per clock, drains at most one write per clock, and forwards pending values.
module rf_writeback_queue #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_reg,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          fwd_reg,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);

  logic [ADDR_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic push;
  logic legal;
  logic store;
  logic pop;

  assign in_ready = (count != DEPTH_C);
  assign push     = in_valid && in_ready;
  assign legal    = ({1'b0, in_reg} < NUM_REGS_C);
  assign store    = push && legal;
  assign pop      = (count != '0);

  // Entry storage is intentionally left out of reset; validity comes from the pointers.
  always_ff @(posedge clock) begin
    if (store) begin
      mem_reg[wr_ptr]  <= in_reg;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wr_en       <= 1'b0;
      wr_reg      <= '0;
      wr_data     <= '0;
      err_illegal <= 1'b0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_reg  <= mem_reg[rd_ptr];
        wr_data <= mem_data[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push && !legal) begin
        err_illegal <= 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest (wr stage first, then FIFO head to tail) so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (wr_en && (wr_reg == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_reg[idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: latency, ordering, forwarding, illegal index and async reset.
module tb_rf_writeback_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_reg;
  logic [63:0] in_data;
  logic        wr_en;
  logic [5:0]  wr_reg;
  logic [63:0] wr_data;
  logic [5:0]  fwd_reg;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [2:0]  count;
  logic        err_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_writeback_queue dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .err_illegal(err_illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    fwd_reg  = 6'd0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_reg", 64'(wr_reg), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    reset_n = 1'b1;

    // single push: visible on wr_* one edge after acceptance
    in_valid = 1'b1; in_reg = 6'd5; in_data = 64'h0000_0000_DEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("p1_count", 64'(count), 64'd1);
    chk("p1_wr_en", 64'(wr_en), 64'd0);
    tick();
    chk("p2_wr_en", 64'(wr_en), 64'd1);
    chk("p2_wr_reg", 64'(wr_reg), 64'd5);
    chk("p2_wr_data", wr_data, 64'h0000_0000_DEAD_BEEF);
    chk("p2_count", 64'(count), 64'd0);
    tick();
    chk("p3_wr_en", 64'(wr_en), 64'd0);
    chk("p3_wr_reg_hold", 64'(wr_reg), 64'd5);
    chk("p3_wr_data_hold", wr_data, 64'h0000_0000_DEAD_BEEF);

    // back-to-back stream 1..5
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_reg = 6'(k); in_data = 64'(k) * 64'h101;
      tick();
      chk("bb_ready", 64'(in_ready), 64'd1);
      chk("bb_count", 64'(count), 64'd1);
      if (k > 1) begin
        chk("bb_wr_en", 64'(wr_en), 64'd1);
        chk("bb_wr_reg", 64'(wr_reg), 64'(k - 1));
        chk("bb_wr_data", wr_data, 64'(k - 1) * 64'h101);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("bb_last_reg", 64'(wr_reg), 64'd5);
    chk("bb_last_data", wr_data, 64'h505);
    chk("bb_last_count", 64'(count), 64'd0);
    tick();
    chk("bb_idle", 64'(wr_en), 64'd0);

    // forwarding: same register twice, youngest wins
    in_valid = 1'b1; in_reg = 6'd7; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    in_valid = 1'b0;
    fwd_reg = 6'd7;
    #1;
    chk("fwd7_hit", 64'(fwd_hit), 64'd1);
    chk("fwd7_data", fwd_data, 64'h22);
    fwd_reg = 6'd3;
    #1;
    chk("fwd3_hit", 64'(fwd_hit), 64'd0);
    chk("fwd3_data", fwd_data, 64'd0);
    fwd_reg = 6'd7;
    tick();
    chk("fwd7_wr_hit", 64'(fwd_hit), 64'd1);
    chk("fwd7_wr_data", fwd_data, 64'h22);
    tick();
    chk("fwd7_gone_hit", 64'(fwd_hit), 64'd0);
    chk("fwd7_gone_data", fwd_data, 64'd0);

    // forwarding: wr stage and FIFO entry hold different registers
    in_valid = 1'b1; in_reg = 6'd9; in_data = 64'hAA;
    tick();
    in_reg = 6'd10; in_data = 64'hBB;
    tick();
    in_valid = 1'b0;
    fwd_reg = 6'd9;
    #1;
    chk("fwd9_data", fwd_data, 64'hAA);
    fwd_reg = 6'd10;
    #1;
    chk("fwd10_data", fwd_data, 64'hBB);
    tick();
    tick();

    // index boundary: 31 is legal, 32 and 40 are not
    in_valid = 1'b1; in_reg = 6'd31; in_data = 64'h3131;
    tick();
    in_valid = 1'b0;
    chk("r31_err", 64'(err_illegal), 64'd0);
    chk("r31_count", 64'(count), 64'd1);
    tick();
    chk("r31_wr_reg", 64'(wr_reg), 64'd31);
    in_valid = 1'b1; in_reg = 6'd32; in_data = 64'h3232;
    tick();
    in_valid = 1'b0;
    chk("r32_err", 64'(err_illegal), 64'd1);
    chk("r32_count", 64'(count), 64'd0);
    tick();
    chk("r32_no_write", 64'(wr_en), 64'd0);
    in_valid = 1'b1; in_reg = 6'd40; in_data = 64'h4040;
    tick();
    in_valid = 1'b0;
    chk("r40_count", 64'(count), 64'd0);
    tick();
    chk("r40_no_write", 64'(wr_en), 64'd0);
    chk("r40_err_sticky", 64'(err_illegal), 64'd1);

    // async reset while a write is in flight and an entry is pending
    in_valid = 1'b1; in_reg = 6'd12; in_data = 64'hC;
    tick();
    in_reg = 6'd13; in_data = 64'hD;
    tick();
    in_valid = 1'b0;
    chk("mid_wr_en_pre", 64'(wr_en), 64'd1);
    chk("mid_count_pre", 64'(count), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_wr_en", 64'(wr_en), 64'd0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    chk("mid_err_clr", 64'(err_illegal), 64'd0);
    chk("mid_fwd_hit", 64'(fwd_hit), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_wr_en1", 64'(wr_en), 64'd0);
    tick();
    chk("post_rst_wr_en2", 64'(wr_en), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
